sobel_edge_filter: RTL and testbench



---
 rtl/sobel_pkg.sv | 42 ++++
 rtl/sobel_line_buffer.sv | 51 +++++
 rtl/sobel_edge_filter.sv | 166 ++++++++++++++++
 tb/tb_sobel_edge_filter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg
// Shared constants, the 3x3 window type and the arithmetic helpers used by
// the Sobel edge filter. The filter takes the 12-bit grey stream coming out
// of the Bayer-to-grey converter.
//   DATA_W         : grey pixel width
//   LINE_WIDTH_DEF : default number of valid pixels per line
//   MODE_GX/MODE_GY: kernel select values (vertical / horizontal edges)
//   SAT_MAX        : largest value that fits on the output
package sobel_pkg;

  localparam int DATA_W         = 12;
  localparam int LINE_WIDTH_DEF = 640;
  localparam int SUM_W          = 14;
  localparam int DIFF_W         = 15;

  localparam logic MODE_GX = 1'b0;
  localparam logic MODE_GY = 1'b1;

  localparam logic [DATA_W-1:0] SAT_MAX = 12'hFFF;

  // Indexed as [row][col]. Row 0 is the oldest line and col 2 is the newest pixel.
  typedef logic [2:0][2:0][DATA_W-1:0] window_t;

  // The 1-2-1 weighting shared by both kernels. The worst case is 4*4095,
  // which still fits in 14 bits.
  function automatic logic [SUM_W-1:0] weightedSum(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] c);
    weightedSum = SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
  endfunction

  // |pos - neg|, clamped to the output range.
  function automatic logic [DATA_W-1:0] absSat(input logic [SUM_W-1:0] pos,
                                               input logic [SUM_W-1:0] neg);
    logic signed [DIFF_W-1:0] diff;
    logic        [DIFF_W-1:0] mag;
    diff = $signed({1'b0, pos}) - $signed({1'b0, neg});
    mag  = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);
    absSat = (mag > DIFF_W'(SAT_MAX)) ? SAT_MAX : mag[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer
// Two cascaded DEPTH-deep shift lines that advance only when i_en is high.
// They are built as circular RAMs that share one pointer.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (clears the pointer only)
//   i_en   : advance enable (one step per valid pixel)
//   i_data : newest pixel
//   o_tap1 : pixel that entered DEPTH steps ago (same column, one line up)
//   o_tap2 : pixel that entered 2*DEPTH steps ago (same column, two lines up)
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_tap1,
  output logic [WIDTH-1:0] o_tap2
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_line1 [DEPTH];
  logic [WIDTH-1:0] r_line2 [DEPTH];
  logic [PTR_W-1:0] r_ptr;

  // The slot under the pointer holds the oldest entry of each line.
  // Reading it before it is overwritten gives exactly one line of delay.
  assign o_tap1 = r_line1[r_ptr];
  assign o_tap2 = r_line2[r_ptr];

  // The pointer walks the ring once per line of valid pixels.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  // The storage is left unreset. The evicted line-1 entry is cascaded into
  // line 2, so line 2 lags line 1 by one full line.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_line1[r_ptr] <= i_data;
      r_line2[r_ptr] <= r_line1[r_ptr];
    end
  end

endmodule

// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter
// Sobel gradient magnitude on a streaming grey image. It uses a 3x3 window
// fed by two line buffers and a 2-stage pipeline, and produces one output per
// input pixel. Window positions on the image border produce 0.
//   iCLK  : pixel clock
//   iRST  : synchronous active-high reset
//   iGrey : grey pixel, sampled when iDVAL=1
//   iDVAL : input pixel valid (gaps allowed)
//   iFVAL : frame valid; low clears the row and column counters
//   iMode : 0 = Gx (vertical edges), 1 = Gy (horizontal edges);
//           captured on the iFVAL rising edge
//   oEdge : saturated gradient magnitude
//   oDVAL : output valid, iDVAL delayed by exactly two clocks
module sobel_edge_filter
  import sobel_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iGrey,
  input  logic              iDVAL,
  input  logic              iFVAL,
  input  logic              iMode,
  output logic [DATA_W-1:0] oEdge,
  output logic              oDVAL
);

  logic [9:0]        r_col;
  logic [9:0]        r_row;
  logic              r_fvalPrev;
  logic              r_mode;
  window_t           r_win;
  logic [SUM_W-1:0]  r_sumPos;
  logic [SUM_W-1:0]  r_sumNeg;
  logic              r_border;
  logic              r_valid1;

  logic [DATA_W-1:0] w_tap1;
  logic [DATA_W-1:0] w_tap2;
  logic              w_fvalRise;
  logic              w_modeEff;
  window_t           w_winNext;
  logic [SUM_W-1:0]  w_sumPos;
  logic [SUM_W-1:0]  w_sumNeg;
  logic              w_border;

  sobel_line_buffer #(
    .DEPTH (LINE_WIDTH),
    .WIDTH (DATA_W)
  ) u_lineBuf (
    .i_clk  (iCLK),
    .i_rst  (iRST),
    .i_en   (iDVAL),
    .i_data (iGrey),
    .o_tap1 (w_tap1),
    .o_tap2 (w_tap2)
  );

  // Row/column position of the incoming pixel. A low iFVAL wins over iDVAL.
  // The last pixel of a frame can arrive while iFVAL is falling. That pixel
  // still uses the current counts, and the counters clear on the next cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_col <= '0;
      r_row <= '0;
    end else if (!iFVAL) begin
      r_col <= '0;
      r_row <= '0;
    end else if (iDVAL) begin
      if (r_col == 10'(LINE_WIDTH - 1)) begin
        r_col <= '0;
        if (r_row != 10'd1023) begin
          r_row <= r_row + 10'd1;
        end
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  // The kernel is chosen once per frame, so a switch that moves mid-frame
  // cannot mix Gx and Gy results in one image.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_fvalPrev <= 1'b0;
      r_mode     <= MODE_GX;
    end else begin
      r_fvalPrev <= iFVAL;
      if (w_fvalRise) begin
        r_mode <= iMode;
      end
    end
  end

  assign w_fvalRise = iFVAL && !r_fvalPrev;
  assign w_modeEff  = w_fvalRise ? iMode : r_mode;

  // The next window is the current one shifted left, with the newest
  // column built from the two line-buffer taps and the live pixel.
  always_comb begin
    w_winNext = r_win;
    for (int rr = 0; rr < 3; rr++) begin
      w_winNext[rr][0] = r_win[rr][1];
      w_winNext[rr][1] = r_win[rr][2];
    end
    w_winNext[0][2] = w_tap2;
    w_winNext[1][2] = w_tap1;
    w_winNext[2][2] = iGrey;
  end

  // The window moves only on valid pixels. Its contents are not reset
  // because the border flag masks anything left over.
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      r_win <= w_winNext;
    end
  end

  // The sums are formed from the window that includes the current pixel,
  // which keeps the latency at two clocks. The pixel at (r, c) completes the
  // window centred on (r-1, c-1), so that window lies on the border when
  // r<2 or c<2.
  always_comb begin
    if (w_modeEff == MODE_GY) begin
      w_sumPos = weightedSum(w_winNext[2][0], w_winNext[2][1], w_winNext[2][2]);
      w_sumNeg = weightedSum(w_winNext[0][0], w_winNext[0][1], w_winNext[0][2]);
    end else begin
      w_sumPos = weightedSum(w_winNext[0][2], w_winNext[1][2], w_winNext[2][2]);
      w_sumNeg = weightedSum(w_winNext[0][0], w_winNext[1][0], w_winNext[2][0]);
    end
    w_border = (r_row < 10'd2) || (r_col < 10'd2);
  end

  // Stage 1 holds the two weighted sums and the border flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_valid1 <= 1'b0;
      r_sumPos <= '0;
      r_sumNeg <= '0;
      r_border <= 1'b1;
    end else begin
      r_valid1 <= iDVAL;
      if (iDVAL) begin
        r_sumPos <= w_sumPos;
        r_sumNeg <= w_sumNeg;
        r_border <= w_border;
      end
    end
  end

  // Stage 2 holds the magnitude, or 0 on the border. oEdge keeps its last
  // value between valid outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oEdge <= '0;
    end else begin
      oDVAL <= r_valid1;
      if (r_valid1) begin
        oEdge <= r_border ? '0 : absSat(r_sumPos, r_sumNeg);
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// tb_sobel_edge_filter
// Streams whole frames into sobel_edge_filter. Each output pixel is compared
// with a Sobel value computed directly on a stored image. The oDVAL timing is
// compared with the input valid history on every cycle.
module tb_sobel_edge_filter;
  import sobel_pkg::*;

  localparam int LW   = 640;
  localparam int ROWS = 8;

  logic              iCLK  = 1'b0;
  logic              iRST  = 1'b1;
  logic [DATA_W-1:0] iGrey = '0;
  logic              iDVAL = 1'b0;
  logic              iFVAL = 1'b0;
  logic              iMode = 1'b0;
  logic [DATA_W-1:0] oEdge;
  logic              oDVAL;

  int checks   = 0;
  int errors   = 0;
  int outCount = 0;
  int img [ROWS][LW];
  int expQ [$];

  bit dv1  = 1'b0;
  bit dv2  = 1'b0;
  bit rst1 = 1'b1;
  bit rst2 = 1'b1;

  sobel_edge_filter #(.LINE_WIDTH(LW)) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iGrey (iGrey),
    .iDVAL (iDVAL),
    .iFVAL (iFVAL),
    .iMode (iMode),
    .oEdge (oEdge),
    .oDVAL (oDVAL)
  );

  always #5 iCLK = ~iCLK;

  // Hard time limit so that a stuck bench still terminates.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Sobel magnitude for the window centred on (r-1, c-1), computed on the
  // stored image.
  function automatic int expEdge(input int r, input int c, input bit mode);
    int pos;
    int neg;
    int g;
    if (r < 2 || c < 2) return 0;
    if (mode == MODE_GX) begin
      pos = img[r-2][c]   + 2*img[r-1][c]   + img[r][c];
      neg = img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2];
    end else begin
      pos = img[r][c-2]   + 2*img[r][c-1]   + img[r][c];
      neg = img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c];
    end
    g = pos - neg;
    if (g < 0) g = -g;
    if (g > 4095) g = 4095;
    return g;
  endfunction

  // Sends one pixel after a random idle gap and queues its expected result.
  task automatic applyStimulus(input int value, input int expv, input int gapMax, input bit dropFval);
    int gap;
    gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
    for (int g = 0; g < gap; g++) begin
      @(posedge iCLK); #1;
      iDVAL = 1'b0;
    end
    @(posedge iCLK); #1;
    iDVAL = 1'b1;
    iGrey = DATA_W'(value);
    if (dropFval) iFVAL = 1'b0;
    expQ.push_back(expv);
  endtask

  task automatic startFrame(input bit mode);
    @(posedge iCLK); #1;
    iFVAL = 1'b0;
    iDVAL = 1'b0;
    iMode = mode;
    repeat (2) @(posedge iCLK);
    #1 iFVAL = 1'b1;
    @(posedge iCLK); #1;
    outCount = 0;
  endtask

  task automatic endFrame(input string tag, input int nPix);
    @(posedge iCLK); #1;
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    for (int t = 0; t < 20 && expQ.size() > 0; t++) @(negedge iCLK);
    @(negedge iCLK);
    checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, "_count"}, 32'(outCount), 32'(nPix));
  endtask

  // The last pixel of a frame is sent with iFVAL already low. Setting
  // toggleAt >= 0 flips iMode in the middle of the frame.
  task automatic runFrame(input bit mode, input int gapMax, input int toggleAt, input string tag);
    startFrame(mode);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < LW; c++) begin
        if (r*LW + c == toggleAt) iMode = ~mode;
        applyStimulus(img[r][c], expEdge(r, c, mode), gapMax,
                      (r == ROWS-1) && (c == LW-1));
      end
    end
    endFrame(tag, ROWS*LW);
  endtask

  task automatic fillVStep(input int lo, input int hi);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < LW; c++)
        img[r][c] = (c < 8) ? lo : hi;
  endtask

  // Each cycle: oDVAL must equal iDVAL from two cycles back, unless a reset
  // flushed that pixel. Every valid output is matched against the queue.
  always @(negedge iCLK) begin
    bit expDv;
    int e;
    expDv = dv2 && !rst1 && !rst2;
    checkOutput("oDVAL_timing", 32'(oDVAL), 32'(expDv));
    if (oDVAL) begin
      outCount++;
      checkOutput("expected_available", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("oEdge", 32'(oEdge), 32'(e));
      end
    end
    if (iRST) expQ.delete();
    rst2 = rst1;
    rst1 = iRST;
    dv2  = dv1;
    dv1  = iDVAL;
  end

  initial begin
    int fr;
    bit rmode;

    // Reset state.
    repeat (4) @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("reset_oDVAL", 32'(oDVAL), 32'd0);
    checkOutput("reset_oEdge", 32'(oEdge), 32'd0);
    @(posedge iCLK); #1;
    iRST = 1'b0;

    // Flat image: zero gradient everywhere.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < LW; c++)
        img[r][c] = 1000;
    runFrame(MODE_GX, 0, -1, "flat");

    // Vertical step of height 100.
    fillVStep(0, 100);
    runFrame(MODE_GX, 0, -1, "vstep_gx");
    runFrame(MODE_GY, 0, -1, "vstep_gy");

    // Full-scale step drives the output to its saturation value.
    fillVStep(0, 4095);
    runFrame(MODE_GX, 0, -1, "vstep_sat");

    // Horizontal step of height 200.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < LW; c++)
        img[r][c] = (r < 4) ? 0 : 200;
    runFrame(MODE_GY, 0, -1, "hstep_gy");

    // Step of height 100 with random input gaps and a mid-frame iMode flip.
    fillVStep(0, 100);
    runFrame(MODE_GX, 3, 2000, "vstep_gaps");

    // Random image in a random mode, with gaps.
    rmode = 1'($urandom_range(0, 1));
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < LW; c++)
        img[r][c] = int'($urandom_range(0, 4095));
    runFrame(rmode, 2, -1, "random");

    // Reset arrives in the middle of a frame, at row 5 col 100.
    fillVStep(0, 100);
    startFrame(MODE_GX);
    fr = 5*LW + 100;
    for (int k = 0; k < fr; k++)
      applyStimulus(img[k / LW][k % LW], expEdge(k / LW, k % LW, MODE_GX), 0, 1'b0);
    @(posedge iCLK); #1;
    iRST  = 1'b1;
    iDVAL = 1'b1;
    iGrey = DATA_W'(img[5][100]);
    @(posedge iCLK); #1;
    iRST  = 1'b0;
    iDVAL = 1'b0;
    @(negedge iCLK);
    checkOutput("midreset_oDVAL", 32'(oDVAL), 32'd0);
    checkOutput("midreset_oEdge", 32'(oEdge), 32'd0);
    checkOutput("midreset_known", 32'($isunknown(oEdge)), 32'd0);
    outCount = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < LW; c++)
        applyStimulus(img[r][c], expEdge(r, c, MODE_GX), 0, (r == 3) && (c == LW-1));
    endFrame("after_reset", 4*LW);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
